// File: rtl/riscv_trap_ctrl_pkg.sv
// Shared defines (widths, CSR addresses, mstatus fields, cause codes,
// FSM encodings) and the trap-control package with mstatus helpers.
`ifndef RISCV_TRAP_DEFINES
`define RISCV_TRAP_DEFINES
`define DATA_WIDTH 32
`define CSR_REG_WIDTH 12
`define CSR_MSTATUS 12'h300
`define CSR_MTVEC 12'h305
`define CSR_MEPC 12'h341
`define CSR_MCAUSE 12'h342
`define MSTATUS_MIE 3
`define MSTATUS_MPIE 7
`define MSTATUS_MPP_HI 12
`define MSTATUS_MPP_LO 11
`define CAUSE_ILLEGAL 2
`define CAUSE_EBREAK 3
`define CAUSE_ECALL 11
`define TRAP_ST_IDLE 2'd0
`define TRAP_ST_TRAP_WR 2'd1
`define TRAP_ST_MRET_WR 2'd2
`define TRAP_ST_REDIRECT 2'd3
`endif

package riscv_trap_ctrl_pkg;

  localparam int DW = `DATA_WIDTH;

  typedef logic [DW-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE     = `TRAP_ST_IDLE,
    TRAP_WR  = `TRAP_ST_TRAP_WR,
    MRET_WR  = `TRAP_ST_MRET_WR,
    REDIRECT = `TRAP_ST_REDIRECT
  } trap_state_e;

  function automatic word_t trap_mstatus(input word_t s);
    word_t r;
    r = s;
    r[`MSTATUS_MPIE] = s[`MSTATUS_MIE];
    r[`MSTATUS_MIE] = 1'b0;
    r[`MSTATUS_MPP_HI:`MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic word_t mret_mstatus(input word_t s);
    word_t r;
    r = s;
    r[`MSTATUS_MIE] = s[`MSTATUS_MPIE];
    r[`MSTATUS_MPIE] = 1'b1;
    r[`MSTATUS_MPP_HI:`MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/riscv_dff.sv
// Enabled register with asynchronous active-low clear.
// Ports: clk, rst_n, en, d[W], q[W].
module riscv_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/riscv_trap_ctrl.sv
// Machine-mode trap / MRET sequencer: writes mstatus/mepc/mcause,
// then holds a PC redirect until fetch accepts it; busy while active.
module riscv_trap_ctrl
  import riscv_trap_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inst_valid_i,
  input  logic [`DATA_WIDTH-1:0] inst_pc_i,
  input  logic                   ecall_i,
  input  logic                   ebreak_i,
  input  logic                   illegal_i,
  input  logic                   mret_i,
  input  logic [`DATA_WIDTH-1:0] csr_mstatus_read_data_i,
  input  logic [`DATA_WIDTH-1:0] csr_mepc_read_data_i,
  input  logic [`DATA_WIDTH-1:0] csr_mtvec_read_data_i,
  output logic [`DATA_WIDTH-1:0] csr_mstatus_write_data_o,
  output logic                   csr_mstatus_write_valid_o,
  output logic [`DATA_WIDTH-1:0] csr_mepc_write_data_o,
  output logic                   csr_mepc_write_valid_o,
  output logic [`DATA_WIDTH-1:0] csr_mcause_write_data_o,
  output logic                   csr_mcause_write_valid_o,
  output logic                   redirect_valid_o,
  output logic [`DATA_WIDTH-1:0] redirect_pc_o,
  input  logic                   redirect_ready_i,
  output logic                   busy_o
);

  logic [1:0]  state_raw;
  trap_state_e state_q;
  trap_state_e state_d;
  word_t       pc_q;
  word_t       cause_q;
  word_t       cause_d;
  word_t       target_q;
  word_t       target_d;
  logic        is_exc;
  logic        accept;
  logic        target_en;

  assign state_q = trap_state_e'(state_raw);
  assign is_exc  = illegal_i | ebreak_i | ecall_i;
  assign accept  = (state_q == IDLE) && inst_valid_i
                && (is_exc || mret_i);

  assign target_en = (state_q == TRAP_WR)
                  || (state_q == MRET_WR);

  // mtvec mode bits are dropped: direct mode only
  assign target_d = (state_q == TRAP_WR)
                  ? (csr_mtvec_read_data_i & ~word_t'(3))
                  : csr_mepc_read_data_i;

  always_comb begin
    cause_d = '0;
    priority case (1'b1)
      illegal_i: cause_d = word_t'(`CAUSE_ILLEGAL);
      ebreak_i:  cause_d = word_t'(`CAUSE_EBREAK);
      ecall_i:   cause_d = word_t'(`CAUSE_ECALL);
      default:   cause_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = is_exc ? TRAP_WR : MRET_WR;
        end
      end
      TRAP_WR:  state_d = REDIRECT;
      MRET_WR:  state_d = REDIRECT;
      REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  riscv_dff #(.W(2)) u_state (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .d    (state_d),
    .q    (state_raw)
  );

  riscv_dff #(.W(DW)) u_pc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .d    (inst_pc_i),
    .q    (pc_q)
  );

  riscv_dff #(.W(DW)) u_cause (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .d    (cause_d),
    .q    (cause_q)
  );

  riscv_dff #(.W(DW)) u_target (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (target_en),
    .d    (target_d),
    .q    (target_q)
  );

  always_comb begin
    csr_mstatus_write_data_o  = '0;
    csr_mstatus_write_valid_o = 1'b0;
    csr_mepc_write_data_o     = '0;
    csr_mepc_write_valid_o    = 1'b0;
    csr_mcause_write_data_o   = '0;
    csr_mcause_write_valid_o  = 1'b0;
    redirect_valid_o          = 1'b0;
    redirect_pc_o             = '0;
    unique case (state_q)
      TRAP_WR: begin
        csr_mstatus_write_valid_o = 1'b1;
        csr_mstatus_write_data_o  =
          trap_mstatus(csr_mstatus_read_data_i);
        csr_mepc_write_valid_o    = 1'b1;
        csr_mepc_write_data_o     = pc_q & ~word_t'(3);
        csr_mcause_write_valid_o  = 1'b1;
        csr_mcause_write_data_o   = cause_q;
      end
      MRET_WR: begin
        csr_mstatus_write_valid_o = 1'b1;
        csr_mstatus_write_data_o  =
          mret_mstatus(csr_mstatus_read_data_i);
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Randomized + directed bench for riscv_trap_ctrl against a
// transaction-level model of trap/MRET sequencing.
module tb_riscv_trap_ctrl;

  localparam int W = `DATA_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         inst_valid = 1'b0;
  logic [W-1:0] inst_pc = '0;
  logic         ecall = 1'b0;
  logic         ebreak = 1'b0;
  logic         illegal = 1'b0;
  logic         mret = 1'b0;
  logic [W-1:0] ms_rd = '0;
  logic [W-1:0] mepc_rd = '0;
  logic [W-1:0] mtvec_rd = '0;
  logic [W-1:0] ms_wd;
  logic         ms_wv;
  logic [W-1:0] mepc_wd;
  logic         mepc_wv;
  logic [W-1:0] mcause_wd;
  logic         mcause_wv;
  logic         rv;
  logic [W-1:0] rpc;
  logic         rready = 1'b0;
  logic         busy;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  riscv_trap_ctrl dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .inst_valid_i             (inst_valid),
    .inst_pc_i                (inst_pc),
    .ecall_i                  (ecall),
    .ebreak_i                 (ebreak),
    .illegal_i                (illegal),
    .mret_i                   (mret),
    .csr_mstatus_read_data_i  (ms_rd),
    .csr_mepc_read_data_i     (mepc_rd),
    .csr_mtvec_read_data_i    (mtvec_rd),
    .csr_mstatus_write_data_o (ms_wd),
    .csr_mstatus_write_valid_o(ms_wv),
    .csr_mepc_write_data_o    (mepc_wd),
    .csr_mepc_write_valid_o   (mepc_wv),
    .csr_mcause_write_data_o  (mcause_wd),
    .csr_mcause_write_valid_o (mcause_wv),
    .redirect_valid_o         (rv),
    .redirect_pc_o            (rpc),
    .redirect_ready_i         (rready),
    .busy_o                   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_trap_ms(input logic [W-1:0] s);
    logic [W-1:0] mie;
    mie = (s >> 3) & 1;
    return (s & ~W'(32'h88)) | (mie << 7) | W'(32'h1800);
  endfunction

  function automatic logic [W-1:0] ref_mret_ms(input logic [W-1:0] s);
    logic [W-1:0] mpie;
    mpie = (s >> 7) & 1;
    return (s & ~W'(32'h88)) | (mpie << 3)
         | W'(32'h80) | W'(32'h1800);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    inst_valid = 1'b0;
    ecall = 1'b0;
    ebreak = 1'b0;
    illegal = 1'b0;
    mret = 1'b0;
    rready = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".wv"}, W'({ms_wv, mepc_wv, mcause_wv}), '0);
    chk({tag, ".wd"}, ms_wd | mepc_wd | mcause_wd, '0);
  endtask

  task automatic run_event(input logic v, input logic il,
                           input logic eb, input logic ec,
                           input logic mr, input logic [W-1:0] pc,
                           input logic [W-1:0] ms,
                           input logic [W-1:0] epc,
                           input logic [W-1:0] tvec,
                           input int delay, input logic noise);
    bit           trap;
    bit           ret;
    logic [W-1:0] cause;
    logic [W-1:0] tgt;
    trap  = v && (il || eb || ec);
    ret   = v && !trap && mr;
    cause = il ? W'(2) : eb ? W'(3) : W'(11);
    tgt   = trap ? ((tvec >> 2) << 2) : epc;

    chk("idle.busy", W'(busy), '0);
    chk("idle.rv", W'(rv), '0);
    chk_quiet("idle");
    inst_valid = v;
    illegal = il;
    ebreak = eb;
    ecall = ec;
    mret = mr;
    inst_pc = pc;
    ms_rd = ms;
    mepc_rd = epc;
    mtvec_rd = tvec;
    rready = 1'($urandom_range(0, 1));
    tick;
    clear_in;
    if (!trap && !ret) begin
      chk("none.busy", W'(busy), '0);
      chk_quiet("none");
      return;
    end
    if (noise) begin
      inst_valid = 1'b1;
      ecall = 1'b1;
      illegal = 1'($urandom_range(0, 1));
      inst_pc = $urandom;
    end
    chk("wr.busy", W'(busy), W'(1));
    chk("wr.rv", W'(rv), '0);
    if (trap) begin
      chk("trap.wv", W'({ms_wv, mepc_wv, mcause_wv}), W'(7));
      chk("trap.mepc", mepc_wd, pc & ~W'(3));
      chk("trap.mcause", mcause_wd, cause);
      chk("trap.mstatus", ms_wd, ref_trap_ms(ms));
    end else begin
      chk("mret.wv", W'({ms_wv, mepc_wv, mcause_wv}), W'(4));
      chk("mret.mstatus", ms_wd, ref_mret_ms(ms));
    end
    rready = 1'($urandom_range(0, 1));
    tick;
    for (int d = 0; d <= delay; d++) begin
      chk("rd.rv", W'(rv), W'(1));
      chk("rd.pc", rpc, tgt);
      chk("rd.busy", W'(busy), W'(1));
      chk_quiet("rd");
      rready = (d == delay);
      tick;
    end
    clear_in;
    chk("after.busy", W'(busy), '0);
    chk("after.rv", W'(rv), '0);
  endtask

  initial begin
    #3;
    chk("rst.busy", W'(busy), '0);
    chk("rst.rv", W'(rv), '0);
    chk("rst.rpc", rpc, '0);
    chk_quiet("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // ecall
    run_event(1, 0, 0, 1, 0, 32'h8000_0104, 32'h1808,
              32'h0, 32'h8000_1001, 0, 0);
    // mret
    run_event(1, 0, 0, 0, 1, 32'h8000_0200, 32'h1880,
              32'h8000_0108, 32'h8000_1001, 1, 0);
    // priority illegal over ecall
    run_event(1, 1, 0, 1, 0, 32'h8000_0302, 32'h0,
              32'h0, 32'h8000_2000, 0, 0);
    // mret with ebreak takes ebreak
    run_event(1, 0, 1, 0, 1, 32'h8000_0400, 32'h88,
              32'h1234_5678, 32'h8000_3003, 0, 0);
    // backpressure
    run_event(1, 0, 0, 1, 0, 32'h8000_0500, 32'h1808,
              32'h0, 32'h8000_4000, 5, 0);
    // busy drop
    run_event(1, 0, 0, 1, 0, 32'h8000_0600, 32'h8,
              32'h0, 32'h8000_5000, 3, 1);
    // flags without valid
    run_event(0, 1, 1, 1, 1, 32'h8000_0700, 32'h8,
              32'h0, 32'h8000_6000, 0, 0);

    // reset during REDIRECT
    inst_valid = 1'b1;
    ecall = 1'b1;
    mtvec_rd = 32'h8000_7000;
    tick;
    clear_in;
    tick;
    chk("ra.rv", W'(rv), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ra.rv0", W'(rv), '0);
    chk("ra.busy0", W'(busy), '0);
    chk("ra.rpc0", rpc, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rready = 1'($urandom_range(0, 1));
      tick;
      chk("ra.post.rv", W'(rv), '0);
      chk("ra.post.busy", W'(busy), '0);
      chk_quiet("ra.post");
    end
    clear_in;

    // reset during TRAP_WR
    inst_valid = 1'b1;
    ebreak = 1'b1;
    tick;
    clear_in;
    chk("rt.wv", W'({ms_wv, mepc_wv, mcause_wv}), W'(7));
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("rt.rst");
    chk("rt.busy0", W'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rt.post.rv", W'(rv), '0);
      chk_quiet("rt.post");
    end

    for (int i = 0; i < 60; i++) begin
      run_event($urandom_range(0, 7) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0,
                $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
